bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/ser_pkg.sv | 26 ++
 rtl/ser_bit_counter.sv | 36 +++
 rtl/bit_serializer.sv | 136 +++++++++++++
 tb/tb_bit_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding, the
// default word width and the counter-width helper.
// Optional feature macro: SERIALIZER_PARITY_EN (adds the PARITY state).
package ser_pkg;

    localparam int SER_WIDTH_DEFAULT = 8;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } ser_state_e;
`endif

    // Bits needed to hold a count from 0 up to and including max_count.
    function automatic int ser_cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Frame bit counter for the serializer. Holds the number of frame data
// bits presented so far (including the one currently on W). A load starts
// a new frame at 1, clear returns to 0, and enable advances the count,
// saturating at MAX so the value can never wrap.
module ser_bit_counter
    import ser_pkg::*;
#(
    parameter int MAX = SER_WIDTH_DEFAULT,
    parameter int CW  = ser_cnt_width(MAX)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          tc
);

    // Load has priority so a back-to-back frame restarts cleanly at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

    // Terminal count: the last data bit of the frame is on W.
    assign tc = (count == CW'(MAX));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding a downstream FSM W input.
// A word is accepted on a valid/ready transfer and emitted MSB first, one
// bit per clock, on the registered outputs W / w_valid / w_last.
// Optional feature macro: SERIALIZER_PARITY_EN appends one even-parity bit
// after the data bits.
//
// Handshake: a word transfers on any posedge where in_valid and in_ready
// are both 1. in_ready depends only on state and bit counter (never on
// in_valid); it is 1 in IDLE and in the final frame-bit cycle, which lets
// the next frame follow the current one with no idle cycle in between.
// Inputs presented while in_ready is 0 are ignored.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             W,
    output logic             w_valid,
    output logic             w_last,
    output ser_state_e       state_dbg
);

    localparam int CW = ser_cnt_width(WIDTH);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("bit_serializer: WIDTH must be in 1..32");
    end

    ser_state_e       state;
    logic [WIDTH-1:0] shreg;      // bits still to be emitted, next at MSB
    logic [CW-1:0]    bit_cnt;
    logic             cnt_tc;
    logic             final_bit;  // the bit on W now ends the frame
    logic             transfer;
    logic             first_last; // w_last for the first bit of a new frame
    logic             next_last;  // w_last for the next data bit in SHIFT

`ifdef SERIALIZER_PARITY_EN
    logic             parity_q;   // even parity of the captured word

    // With parity the frame ends on the parity cycle, never on a data bit.
    assign final_bit  = (state == ST_PARITY);
    assign first_last = 1'b0;
    assign next_last  = 1'b0;
`else
    assign final_bit  = (state == ST_SHIFT) && cnt_tc;
    assign first_last = (WIDTH == 1);
    assign next_last  = (bit_cnt == CW'(WIDTH - 1));
`endif

    // Ready decoded from state and counter only.
    assign in_ready  = (state == ST_IDLE) || final_bit;
    assign transfer  = in_valid && in_ready;
    assign state_dbg = state;

    ser_bit_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (final_bit && !transfer),
        .load   (transfer),
        .enable ((state == ST_SHIFT) && !cnt_tc),
        .count  (bit_cnt),
        .tc     (cnt_tc)
    );

    // Frame FSM with registered serial outputs. A transfer can only happen
    // in IDLE or on the final bit, and in both cases it starts a new frame
    // by putting the new MSB on W at the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            W       <= 1'b0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (transfer) begin
            state   <= ST_SHIFT;
            W       <= in_data[WIDTH-1];
            shreg   <= in_data << 1;
            w_valid <= 1'b1;
            w_last  <= first_last;
`ifdef SERIALIZER_PARITY_EN
            parity_q <= ^in_data;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!cnt_tc) begin
                        W       <= shreg[WIDTH-1];
                        shreg   <= shreg << 1;
                        w_valid <= 1'b1;
                        w_last  <= next_last;
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        state   <= ST_PARITY;
                        W       <= parity_q;
                        w_valid <= 1'b1;
                        w_last  <= 1'b1;
`else
                        state   <= ST_IDLE;
                        W       <= 1'b0;
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
`endif
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    state   <= ST_IDLE;
                    W       <= 1'b0;
                    w_valid <= 1'b0;
                    w_last  <= 1'b0;
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    W       <= 1'b0;
                    w_valid <= 1'b0;
                    w_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: reset checks, a fixed vector table for a
// single frame, hand sequences for back-to-back, hold-off and mid-frame
// reset, randomized traffic against a queue-based frame model, and a
// WIDTH=1 instance.
module tb_bit_serializer;
    import ser_pkg::*;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, W, w_valid, w_last;
    ser_state_e       state_dbg;

    logic             in_valid1;
    logic [0:0]       in_data1;
    logic             in_ready1, W1, w_valid1, w_last1;
    ser_state_e       state_dbg1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cycle     = 0;

    // Scoreboard: bits of the frame still to appear on W; front is the
    // bit expected on W in the current cycle.
    logic [0:0] exp_q[$];

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             e_w;
        logic             e_v;
        logic             e_l;
        logic             e_r;
    } vec_t;

    vec_t vecs[FLEN+2];

    bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .W         (W),
        .w_valid   (w_valid),
        .w_last    (w_last),
        .state_dbg (state_dbg)
    );

    bit_serializer #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_data   (in_data1),
        .in_ready  (in_ready1),
        .W         (W1),
        .w_valid   (w_valid1),
        .w_last    (w_last1),
        .state_dbg (state_dbg1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %b, expected %b", name, cycle, act, exp);
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    endtask

    task automatic check_outs(input string tag, input logic e_w, input logic e_v,
                              input logic e_l, input logic e_r);
        check1({tag, ".W"},        W,        e_w);
        check1({tag, ".w_valid"},  w_valid,  e_v);
        check1({tag, ".w_last"},   w_last,   e_l);
        check1({tag, ".in_ready"}, in_ready, e_r);
    endtask

    // Expected outputs derived from what is left of the current frame.
    task automatic check_vs_model(input string tag);
        logic e_v, e_w, e_l, e_r;
        e_v = (exp_q.size() > 0);
        e_w = e_v ? exp_q[0] : 1'b0;
        e_l = (exp_q.size() == 1);
        e_r = (exp_q.size() <= 1);
        check_outs(tag, e_w, e_v, e_l, e_r);
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d);
        for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Driver: inputs are already applied; run one clock and update model.
    task automatic advance(input logic v, input logic [WIDTH-1:0] d);
        logic rdy;
        rdy = (exp_q.size() <= 1);
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (v && rdy) push_frame(d);
        @(negedge clk);
    endtask

    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_data  = d;
        check_vs_model(tag);
        advance(v, d);
    endtask

    initial begin
        logic [7:0] wb;
        int         vcount;
        logic       exp1_w[4];

        reset = 1'b0; in_valid = 1'b0; in_data = '0;
        in_valid1 = 1'b0; in_data1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check1("reset.state", state_dbg == ST_IDLE, 1'b1);
        check1("reset1.W", W1, 1'b0);
        check1("reset1.w_valid", w_valid1, 1'b0);
        check1("reset1.in_ready", in_ready1, 1'b1);
        reset = 1'b1;

        // Single frame of 8'hA5, first transfer right after reset release
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SERIALIZER_PARITY_EN
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        vecs[FLEN+1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < FLEN + 2; i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            check_outs($sformatf("vec%0d", i), vecs[i].e_w, vecs[i].e_v,
                       vecs[i].e_l, vecs[i].e_r);
            advance(vecs[i].v, vecs[i].d);
        end

        // Back-to-back: 8'h3C offered during the last bit of 8'hA5
        vcount = 0;
        wb = '0;
        step("b2b", 1'b1, 8'hA5);
        for (int i = 1; i < FLEN; i++) begin
            vcount += int'(w_valid);
            step("b2b", 1'b0, 8'h00);
        end
        vcount += int'(w_valid);
        step("b2b", 1'b1, 8'h3C);
        for (int i = 0; i < FLEN; i++) begin
            vcount += int'(w_valid);
            if (i < 8) wb = {wb[6:0], W};
            step("b2b", 1'b0, 8'h00);
        end
        checkn("b2b.contiguous_valid", vcount, 2 * FLEN);
        checkn("b2b.second_frame", int'(wb), 32'h3C);

        // Hold-off: 8'hFF offered during bits 2..7 must be ignored
        wb = '0;
        step("hold", 1'b1, 8'hA5);
        wb = {wb[6:0], W};
        step("hold", 1'b0, 8'h00);
        for (int i = 2; i <= 7; i++) begin
            wb = {wb[6:0], W};
            check1("hold.in_ready_low", in_ready, 1'b0);
            step("hold", 1'b1, 8'hFF);
        end
        wb = {wb[6:0], W};
        for (int i = 8; i <= FLEN + 1; i++) step("hold", 1'b0, 8'h00);
        checkn("hold.frame", int'(wb), 32'hA5);

        // Reset mid-frame after bit 4
        step("rst", 1'b1, 8'hA5);
        repeat (4) step("rst", 1'b0, 8'h00);
        #2 reset = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.delete();
        @(negedge clk);
        check_outs("rst.held", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        step("rst", 1'b1, 8'h81);
        repeat (FLEN + 1) step("rst", 1'b0, 8'h00);

        // Parity-sensitive word
        step("w01", 1'b1, 8'h01);
        repeat (FLEN + 1) step("w01", 1'b0, 8'h00);

        // Randomized traffic
        repeat (400) begin
            step("rand", ($urandom_range(0, 99) < 60), WIDTH'($urandom));
        end
        in_valid = 1'b0;
        repeat (FLEN + 1) step("drain", 1'b0, 8'h00);

        // WIDTH=1 instance
`ifdef SERIALIZER_PARITY_EN
        in_valid1 = 1'b1; in_data1 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        check1("w1.d.W", W1, 1'b1);
        check1("w1.d.w_last", w_last1, 1'b0);
        check1("w1.d.in_ready", in_ready1, 1'b0);
        @(posedge clk); @(negedge clk);
        check1("w1.p.W", W1, 1'b1);
        check1("w1.p.w_last", w_last1, 1'b1);
        check1("w1.p.in_ready", in_ready1, 1'b1);
`else
        exp1_w = '{1'b1, 1'b0, 1'b1, 1'b0};
        in_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data1 = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk); @(negedge clk);
            check1("w1.W", W1, exp1_w[i]);
            check1("w1.w_valid", w_valid1, 1'b1);
            check1("w1.w_last", w_last1, 1'b1);
            check1("w1.in_ready", in_ready1, 1'b1);
        end
        in_valid1 = 1'b0;
`endif
        @(posedge clk); @(negedge clk);
        check1("w1.idle.w_valid", w_valid1, 1'b0);
        check1("w1.idle.in_ready", in_ready1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
